clock_time_counter: RTL and testbench

- Time-keeping stage of the digital clock, directly downstream of the frequency divider.
- Consumes the divider's clk_1HZ and clk_2HZ as ordinary data inputs sampled in the clk domain, and keeps hh:mm:ss as six BCD digits.
- Provides a button-driven set mode (hours, then minutes) and a per-digit blank mask that blinks the field being set at 2 Hz.
- Feeds the display scan/decoder stage.

---
 rtl/clock_pkg.sv | 50 +++++
 rtl/bcd_mod_counter.sv | 65 ++++++
 rtl/clock_time_counter.sv | 200 ++++++++++++++++++++
 tb/tb_clock_time_counter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
//   Shared definitions for the time-keeping stage of the digital clock.
//   - mode_e       : set-mode state encoding (also the value on the mode port)
//   - *_MAX/*_MIN  : per-field count limits, as plain decimal values
//   - BLANK_*      : bit positions of each digit in the blank request vector,
//                    plus the two-digit masks built from them
//   - bcd2_t       : a two-digit BCD pair (tens, ones)
//   - to_bcd2()    : split a small decimal constant into its BCD digits;
//                    only used on elaboration-time constants, never on data
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HR = 2'd1,
    MODE_SET_MN = 2'd2
  } mode_e;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MAX = 12;
  localparam int HR12_MIN = 1;

  // blank[5] is the hours tens digit, blank[0] the seconds ones digit
  localparam int BLANK_HR_T = 5;
  localparam int BLANK_HR_O = 4;
  localparam int BLANK_MN_T = 3;
  localparam int BLANK_MN_O = 2;
  localparam int BLANK_SC_T = 1;
  localparam int BLANK_SC_O = 0;

  localparam logic [5:0] BLANK_HR_MASK = 6'((1 << BLANK_HR_T) | (1 << BLANK_HR_O));
  localparam logic [5:0] BLANK_MN_MASK = 6'((1 << BLANK_MN_T) | (1 << BLANK_MN_O));
  localparam logic [5:0] BLANK_SC_MASK = 6'((1 << BLANK_SC_T) | (1 << BLANK_SC_O));

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
  } bcd2_t;

  function automatic bcd2_t to_bcd2(int v);
    bcd2_t r;
    r.t = 4'(v / 10);
    r.o = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter running MIN..MAX and wrapping back to MIN.
//   Arithmetic is done per digit (ones 9 -> 0 bumps tens), so the value is
//   always a legal BCD pair and no binary conversion is ever needed.
//
//   Parameters
//     MAX  : highest value held (decimal), e.g. 59 or 23 or 12
//     MIN  : value after a wrap or a clear (decimal), e.g. 0 or 1
//     RST  : value loaded by reset (decimal); defaults to MIN
//   Ports
//     clk   in   system clock
//     rst   in   synchronous, active-high reset -> RST
//     inc   in   advance by one this cycle
//     clr   in   load MIN this cycle (wins over inc)
//     tens  out  BCD tens digit
//     ones  out  BCD ones digit
//     carry out  combinational: inc while at MAX, i.e. this cycle wraps
// -----------------------------------------------------------------------------
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59,
  parameter int MIN = 0,
  parameter int RST = MIN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam bcd2_t MAX_B = to_bcd2(MAX);
  localparam bcd2_t MIN_B = to_bcd2(MIN);
  localparam bcd2_t RST_B = to_bcd2(RST);

  logic at_max;

  assign at_max = (tens == MAX_B.t) && (ones == MAX_B.o);
  assign carry  = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= RST_B.t;
      ones <= RST_B.o;
    end else if (clr) begin
      tens <= MIN_B.t;
      ones <= MIN_B.o;
    end else if (inc) begin
      if (at_max) begin
        tens <= MIN_B.t;
        ones <= MIN_B.o;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_time_counter.sv
// -----------------------------------------------------------------------------
// clock_time_counter
//   Keeps hh:mm:ss as six BCD digits, advanced by the rising edge of the
//   divider's 1 Hz square wave (sampled as data in the clk domain). Two
//   buttons provide a set mode: btn_mode walks RUN -> SET_HR -> SET_MN -> RUN,
//   btn_inc bumps the field being set. The field being set blinks via the
//   blank mask, driven from the 2 Hz square wave.
//
//   Parameters
//     H24      : 1 = hours 00..23, 0 = hours 01..12 (reset shows 12)
//     SYNC_BTN : 1 = two-flop synchroniser on the buttons, 0 = none
//   Ports
//     clk        in   system clock (same as the divider)
//     rst        in   synchronous, active-high reset
//     clk_1HZ    in   1 Hz square wave; rising edge advances time
//     clk_2HZ    in   2 Hz square wave; blink phase only
//     btn_mode   in   debounced level; rising edge advances the mode
//     btn_inc    in   debounced level; rising edge bumps the set field
//     hr_t..sc_o out  BCD digits, tens and ones
//     blank      out  per-digit blank, [5] = hr_t .. [0] = sc_o
//     mode       out  0 RUN, 1 SET_HR, 2 SET_MN
//     sec_tick   out  one-cycle pulse per applied second
// -----------------------------------------------------------------------------
module clock_time_counter
  import clock_pkg::*;
#(
  parameter int H24      = 1,
  parameter int SYNC_BTN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1HZ,
  input  logic       clk_2HZ,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_t,
  output logic [3:0] hr_o,
  output logic [3:0] mn_t,
  output logic [3:0] mn_o,
  output logic [3:0] sc_t,
  output logic [3:0] sc_o,
  output logic [5:0] blank,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam int HR_MAX = (H24 != 0) ? HR24_MAX : HR12_MAX;
  localparam int HR_MIN = (H24 != 0) ? 0        : HR12_MIN;
  localparam int HR_RST = (H24 != 0) ? 0        : HR12_MAX;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic bm_lvl, bi_lvl;

  if (SYNC_BTN != 0) begin : g_sync
    logic [1:0] bm_pipe, bi_pipe;

    // Reset preloads the pipe with the live level so a button held through
    // reset does not look like a fresh press afterwards.
    always_ff @(posedge clk) begin
      if (rst) begin
        bm_pipe <= {2{btn_mode}};
        bi_pipe <= {2{btn_inc}};
      end else begin
        bm_pipe <= {bm_pipe[0], btn_mode};
        bi_pipe <= {bi_pipe[0], btn_inc};
      end
    end

    assign bm_lvl = bm_pipe[1];
    assign bi_lvl = bi_pipe[1];
  end else begin : g_nosync
    assign bm_lvl = btn_mode;
    assign bi_lvl = btn_inc;
  end

  // ---------------------------------------------------------------------------
  // Edge detection. The previous-level registers load the raw input on reset:
  // with the synchroniser that equals what the pipe was just loaded with, so
  // the first post-reset cycle compares like with like.
  // ---------------------------------------------------------------------------
  logic hz1_q, bm_q, bi_q;
  logic tick, mode_edge, inc_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      hz1_q <= clk_1HZ;
      bm_q  <= btn_mode;
      bi_q  <= btn_inc;
    end else begin
      hz1_q <= clk_1HZ;
      bm_q  <= bm_lvl;
      bi_q  <= bi_lvl;
    end
  end

  assign tick      = clk_1HZ && !hz1_q;
  assign mode_edge = bm_lvl && !bm_q;
  assign inc_edge  = bi_lvl && !bi_q;

  // ---------------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------------
  mode_e      state_q, state_d;
  logic       is_run, is_set_hr, is_set_mn;
  logic [5:0] blank_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= MODE_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      case (state_q)
        MODE_RUN:    state_d = MODE_SET_HR;
        MODE_SET_HR: state_d = MODE_SET_MN;
        default:     state_d = MODE_RUN;
      endcase
    end
  end

  // The unused 2'b11 encoding behaves as RUN so the clock keeps running.
  always_comb begin
    is_run    = 1'b0;
    is_set_hr = 1'b0;
    is_set_mn = 1'b0;
    blank_d   = '0;
    case (state_q)
      MODE_SET_HR: begin
        is_set_hr = 1'b1;
        blank_d   = clk_2HZ ? '0 : BLANK_HR_MASK;
      end
      MODE_SET_MN: begin
        is_set_mn = 1'b1;
        blank_d   = clk_2HZ ? '0 : BLANK_MN_MASK;
      end
      default: is_run = 1'b1;
    endcase
  end

  assign mode = state_q;

  // Blank and sec_tick are registered so the display sees clean levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      blank    <= '0;
      sec_tick <= 1'b0;
    end else begin
      blank    <= blank_d & ~BLANK_SC_MASK;
      sec_tick <= is_run && tick;
    end
  end

  // ---------------------------------------------------------------------------
  // Time fields. Carries only ripple in RUN; in set mode the field being set
  // wraps on its own. Any btn_inc edge acts on the mode current this cycle,
  // before the same cycle's btn_mode edge takes effect.
  // ---------------------------------------------------------------------------
  logic sc_inc, sc_clr, mn_inc, hr_inc;
  logic sc_carry, mn_carry, hr_carry_unused;

  assign sc_inc = is_run && tick;
  assign sc_clr = is_set_mn && mode_edge;
  assign mn_inc = (is_run && sc_carry) || (is_set_mn && inc_edge);
  assign hr_inc = (is_run && mn_carry) || (is_set_hr && inc_edge);

  bcd_mod_counter #(.MAX(SEC_MAX), .MIN(0), .RST(0)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (sc_inc),
    .clr   (sc_clr),
    .tens  (sc_t),
    .ones  (sc_o),
    .carry (sc_carry)
  );

  bcd_mod_counter #(.MAX(MIN_MAX), .MIN(0), .RST(0)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (mn_inc),
    .clr   (1'b0),
    .tens  (mn_t),
    .ones  (mn_o),
    .carry (mn_carry)
  );

  bcd_mod_counter #(.MAX(HR_MAX), .MIN(HR_MIN), .RST(HR_RST)) u_hr (
    .clk   (clk),
    .rst   (rst),
    .inc   (hr_inc),
    .clr   (1'b0),
    .tens  (hr_t),
    .ones  (hr_o),
    .carry (hr_carry_unused)
  );

endmodule

// File: tb/tb_clock_time_counter.sv
module tb_clock_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c1 = 1'b0, c2 = 1'b0, bm = 1'b0, bi = 1'b0;

  // index 0: H24 = 1 instance, index 1: H24 = 0 instance (shared inputs)
  logic [3:0] hr_t[2], hr_o[2], mn_t[2], mn_o[2], sc_t[2], sc_o[2];
  logic [5:0] blank[2];
  logic [1:0] mode[2];
  logic       stk[2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clock_time_counter #(.H24(1)) dut24 (
    .clk(clk), .rst(rst), .clk_1HZ(c1), .clk_2HZ(c2), .btn_mode(bm), .btn_inc(bi),
    .hr_t(hr_t[0]), .hr_o(hr_o[0]), .mn_t(mn_t[0]), .mn_o(mn_o[0]),
    .sc_t(sc_t[0]), .sc_o(sc_o[0]), .blank(blank[0]), .mode(mode[0]), .sec_tick(stk[0])
  );

  clock_time_counter #(.H24(0)) dut12 (
    .clk(clk), .rst(rst), .clk_1HZ(c1), .clk_2HZ(c2), .btn_mode(bm), .btn_inc(bi),
    .hr_t(hr_t[1]), .hr_o(hr_o[1]), .mn_t(mn_t[1]), .mn_o(mn_o[1]),
    .sc_t(sc_t[1]), .sc_o(sc_o[1]), .blank(blank[1]), .mode(mode[1]), .sec_tick(stk[1])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] dig(int k);
    return {hr_t[k], hr_o[k], mn_t[k], mn_o[k], sc_t[k], sc_o[k]};
  endfunction

  function automatic logic [23:0] exp_dig(int h, int m, int s);
    logic [23:0] r;
    r = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model: plain integer time plus a list of pending button events
  // that land two cycles after the rise is first seen.
  // ---------------------------------------------------------------------------
  int         mh[2], mm[2], ms[2];
  int         mmode;
  logic [5:0] mbl;
  logic       mstk;
  logic       p1, pbm, pbi;
  logic [1:0] bm_ev, bi_ev;
  bit         mvalid = 0;

  function automatic int hr_next(int k, int h);
    if (k == 0) return (h + 1) % 24;
    return (h == 12) ? 1 : h + 1;
  endfunction

  task automatic model_step();
    logic tk, me, ie;
    if (rst) begin
      mh[0] = 0; mh[1] = 12;
      for (int k = 0; k < 2; k++) begin mm[k] = 0; ms[k] = 0; end
      mmode = 0; mbl = '0; mstk = 1'b0;
      p1 = c1; pbm = bm; pbi = bi; bm_ev = '0; bi_ev = '0;
      mvalid = 1;
    end else begin
      tk = c1 && !p1; p1 = c1;
      me = bm_ev[1]; bm_ev = {bm_ev[0], bm && !pbm}; pbm = bm;
      ie = bi_ev[1]; bi_ev = {bi_ev[0], bi && !pbi}; pbi = bi;
      mbl  = (mmode == 1 && !c2) ? 6'b110000 : (mmode == 2 && !c2) ? 6'b001100 : 6'b000000;
      mstk = (mmode == 0) && tk;
      for (int k = 0; k < 2; k++) begin
        if (mmode == 0 && tk) begin
          ms[k]++;
          if (ms[k] == 60) begin
            ms[k] = 0; mm[k]++;
            if (mm[k] == 60) begin mm[k] = 0; mh[k] = hr_next(k, mh[k]); end
          end
        end
        if (mmode == 1 && ie) mh[k] = hr_next(k, mh[k]);
        if (mmode == 2 && ie) mm[k] = (mm[k] + 1) % 60;
        if (me && mmode == 2) ms[k] = 0;
      end
      if (me) mmode = (mmode + 1) % 3;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model digits[%0d]", k), dig(k), exp_dig(mh[k], mm[k], ms[k]));
        chk($sformatf("model mode[%0d]", k), mode[k], mmode);
        chk($sformatf("model blank[%0d]", k), blank[k], mbl);
        chk($sformatf("model sec_tick[%0d]", k), stk[k], mstk);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed steps (all tasks start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  typedef enum {OP_RST, OP_IDLE, OP_C2, OP_MODE, OP_INC, OP_TICK} op_e;
  typedef struct {
    op_e        op;
    int         n;
    int         h24, h12, mn, sc, md;
    logic [5:0] bl;
  } step_t;

  step_t steps[24];

  task automatic press_mode();
    bm = 1'b1; repeat (4) @(negedge clk);
    bm = 1'b0; repeat (4) @(negedge clk);
  endtask

  task automatic press_inc();
    bi = 1'b1; repeat (4) @(negedge clk);
    bi = 1'b0; repeat (4) @(negedge clk);
  endtask

  task automatic apply_step(step_t s);
    case (s.op)
      OP_RST:  begin rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; repeat (2) @(negedge clk); end
      OP_IDLE: repeat (s.n) @(negedge clk);
      OP_C2:   begin c2 = (s.n != 0); repeat (3) @(negedge clk); end
      OP_MODE: repeat (s.n) press_mode();
      OP_INC:  repeat (s.n) press_inc();
      default: repeat (s.n) begin
                 c1 = 1'b1; repeat (3) @(negedge clk);
                 c1 = 1'b0; repeat (3) @(negedge clk);
               end
    endcase
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      apply_step(steps[i]);
      chk($sformatf("row%0d digits24", i), dig(0), exp_dig(steps[i].h24, steps[i].mn, steps[i].sc));
      chk($sformatf("row%0d digits12", i), dig(1), exp_dig(steps[i].h12, steps[i].mn, steps[i].sc));
      chk($sformatf("row%0d mode", i), {mode[0], mode[1]}, {2'(steps[i].md), 2'(steps[i].md)});
      chk($sformatf("row%0d blank", i), {blank[0], blank[1]}, {steps[i].bl, steps[i].bl});
    end
  endtask

  initial begin
    //          op       n   h24 h12 mn  sc  md  blank
    steps[0]  = '{OP_RST,  1,  0, 12,  0,  0, 0, 6'b000000};
    steps[1]  = '{OP_IDLE, 10, 0, 12,  0,  0, 0, 6'b000000};
    steps[2]  = '{OP_MODE, 1,  0, 12,  0,  0, 1, 6'b110000};
    steps[3]  = '{OP_TICK, 3,  0, 12,  0,  0, 1, 6'b110000};
    steps[4]  = '{OP_INC,  25, 1,  1,  0,  0, 1, 6'b110000};
    steps[5]  = '{OP_C2,   1,  1,  1,  0,  0, 1, 6'b000000};
    steps[6]  = '{OP_INC,  22, 23, 11, 0,  0, 1, 6'b000000};
    steps[7]  = '{OP_C2,   0,  23, 11, 0,  0, 1, 6'b110000};
    steps[8]  = '{OP_MODE, 1,  23, 11, 0,  0, 2, 6'b001100};
    steps[9]  = '{OP_INC,  59, 23, 11, 59, 0, 2, 6'b001100};
    steps[10] = '{OP_INC,  1,  23, 11, 0,  0, 2, 6'b001100};
    steps[11] = '{OP_INC,  59, 23, 11, 59, 0, 2, 6'b001100};
    steps[12] = '{OP_MODE, 1,  23, 11, 59, 0, 0, 6'b000000};
    steps[13] = '{OP_TICK, 58, 23, 11, 59, 58, 0, 6'b000000};
    steps[14] = '{OP_MODE, 1,  0, 12,  0,  0, 1, 6'b110000};
    steps[15] = '{OP_MODE, 1,  0, 12,  0,  0, 2, 6'b001100};
    steps[16] = '{OP_INC,  59, 0, 12,  59, 0, 2, 6'b001100};
    steps[17] = '{OP_MODE, 1,  0, 12,  59, 0, 0, 6'b000000};
    steps[18] = '{OP_TICK, 59, 0, 12,  59, 59, 0, 6'b000000};
    steps[19] = '{OP_TICK, 1,  1,  1,  0,  0, 0, 6'b000000};
    steps[20] = '{OP_MODE, 1,  1,  1,  0,  0, 1, 6'b110000};
    steps[21] = '{OP_INC,  13, 14, 2,  0,  0, 1, 6'b110000};
    steps[22] = '{OP_MODE, 1,  14, 2,  0,  0, 2, 6'b001100};
    steps[23] = '{OP_INC,  37, 14, 2,  37, 0, 2, 6'b001100};

    @(negedge clk);
    run_rows(0, 13);

    // Two ticks from 23:59:58, each landing on the edge that sees the rise.
    for (int t = 0; t < 2; t++) begin
      chk("pre-rise digits24", dig(0), (t == 0) ? exp_dig(23, 59, 58) : exp_dig(23, 59, 59));
      c1 = 1'b1;
      @(posedge clk); #1;
      chk("rise digits24", dig(0), (t == 0) ? exp_dig(23, 59, 59) : exp_dig(0, 0, 0));
      chk("rise digits12", dig(1), (t == 0) ? exp_dig(11, 59, 59) : exp_dig(12, 0, 0));
      chk("rise sec_tick", {stk[0], stk[1]}, 2'b11);
      @(posedge clk); #1;
      chk("after sec_tick", {stk[0], stk[1]}, 2'b00);
      @(negedge clk); c1 = 1'b0;
      repeat (2) @(negedge clk);
    end

    run_rows(14, 23);

    // Reset while in SET_MN at 14:37.
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst digits24", dig(0), exp_dig(0, 0, 0));
    chk("rst digits12", dig(1), exp_dig(12, 0, 0));
    chk("rst mode", {mode[0], mode[1]}, 4'b0000);
    chk("rst blank", {blank[0], blank[1]}, 12'b0);
    rst = 1'b0;
    @(negedge clk); c1 = 1'b1;
    @(posedge clk); #1;
    chk("post-rst tick24", dig(0), exp_dig(0, 0, 1));
    chk("post-rst tick12", dig(1), exp_dig(12, 0, 1));
    @(negedge clk); c1 = 1'b0;
    repeat (2) @(negedge clk);

    // btn_mode edge lands together with a tick: tick applies, mode moves on.
    bm = 1'b1;
    repeat (2) @(negedge clk);
    c1 = 1'b1;
    @(posedge clk); #1;
    chk("mode+tick digits24", dig(0), exp_dig(0, 0, 2));
    chk("mode+tick mode", mode[0], 2'd1);
    chk("mode+tick sec_tick", stk[0], 1'b1);
    @(negedge clk); bm = 1'b0; c1 = 1'b0;
    repeat (4) @(negedge clk);

    // btn_mode and btn_inc together in SET_HR: hours bump, then SET_MN.
    bm = 1'b1; bi = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    chk("mode+inc digits24", dig(0), exp_dig(1, 0, 2));
    chk("mode+inc digits12", dig(1), exp_dig(1, 0, 2));
    chk("mode+inc mode", mode[0], 2'd2);
    @(negedge clk); bm = 1'b0; bi = 1'b0;
    repeat (4) @(negedge clk);
    press_mode();
    chk("leave SET_MN digits24", dig(0), exp_dig(1, 0, 0));
    chk("leave SET_MN mode", mode[0], 2'd0);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 3) == 0)  c1 = ~c1;
      if ($urandom_range(0, 5) == 0)  c2 = ~c2;
      if ($urandom_range(0, 11) == 0) bm = ~bm;
      if ($urandom_range(0, 2) == 0)  bi = ~bi;
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
